// File: rtl/accel_servo_pkg.sv
// Shared constants, FSM encoding and the per-axis control struct for the
// accelerometer-driven servo controller.
package accel_servo_pkg;

    localparam int FRAME_US    = 20000;
    localparam int CENTER_US   = 1500;
    localparam int CLAMP_MIN   = -256;
    localparam int CLAMP_MAX   = 255;
    localparam int SCALE_MUL   = 125;
    localparam int SCALE_SHIFT = 6;
    localparam int HIST_DEPTH  = 4;
    localparam int SAMPLE_W    = 10;
    localparam int WIDTH_W     = 11;
    localparam int SUM_W       = 12;
    localparam int PROD_W      = 18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_SCALE   = 3'd3,
        ST_DONE    = 3'd4
    } servo_state_t;

    typedef struct packed {
        logic capture;
        logic accum;
        logic scale;
        logic done;
    } axis_ctrl_t;

    // Limit a raw sample to +/-1 g.
    function automatic logic signed [SAMPLE_W-1:0] clamp_sample(
        input logic signed [SAMPLE_W-1:0] v
    );
        if (v < SAMPLE_W'(CLAMP_MIN))
            return SAMPLE_W'(CLAMP_MIN);
        else if (v > SAMPLE_W'(CLAMP_MAX))
            return SAMPLE_W'(CLAMP_MAX);
        else
            return v;
    endfunction

endpackage

// File: rtl/servo_axis_map.sv
// One axis of the tilt-to-pulse mapping: clamp, 4-deep moving sum, and
// scaling of the average into a servo pulse width in microseconds.
module servo_axis_map
    import accel_servo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  axis_ctrl_t          ctrl,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [WIDTH_W-1:0]  width_next
);

    logic signed [SAMPLE_W-1:0] clamped;
    logic signed [SAMPLE_W-1:0] hist [HIST_DEPTH];
    logic signed [SUM_W-1:0]    sum;
    logic signed [SUM_W-1:0]    sum_new;
    logic signed [SUM_W-1:0]    avg;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   width_calc;
    logic [WIDTH_W-1:0]         scaled;

    // Sum of the history as it will look after this shift.
    always_comb begin
        sum_new = SUM_W'(clamped);
        for (int i = 0; i < HIST_DEPTH - 1; i++)
            sum_new = sum_new + SUM_W'(hist[i]);
    end

    assign avg        = sum >>> $clog2(HIST_DEPTH);
    assign prod       = PROD_W'(avg) * PROD_W'(SCALE_MUL);
    assign width_calc = PROD_W'(CENTER_US) + (prod >>> SCALE_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            clamped <= '0;
            for (int i = 0; i < HIST_DEPTH; i++)
                hist[i] <= '0;
            sum        <= '0;
            scaled     <= WIDTH_W'(CENTER_US);
            width_next <= WIDTH_W'(CENTER_US);
        end else begin
            if (ctrl.capture)
                clamped <= clamp_sample($signed(sample));
            if (ctrl.accum) begin
                hist[0] <= clamped;
                for (int i = 1; i < HIST_DEPTH; i++)
                    hist[i] <= hist[i-1];
                sum <= sum_new;
            end
            if (ctrl.scale)
                scaled <= width_calc[WIDTH_W-1:0];
            if (ctrl.done)
                width_next <= scaled;
        end
    end

endmodule

// File: rtl/accel_servo_ctrl.sv
// Two-axis servo driver: 1 us timebase, 20 ms PWM frame, and a per-frame
// sequencer that turns accelerometer samples into pulse widths.
module accel_servo_ctrl
    import accel_servo_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int US_DIV       = CLK_FREQ / 1_000_000,
    parameter int FRAME_LEN_US = FRAME_US
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] x_in,
    input  logic [SAMPLE_W-1:0] y_in,
    input  logic                hold,
    output logic                pwm_x,
    output logic                pwm_y,
    output logic [WIDTH_W-1:0]  width_x,
    output logic [WIDTH_W-1:0]  width_y,
    output logic                sample_valid
);

    localparam int NUM_AXES = 2;
    localparam int PRE_W    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int US_W     = $clog2(FRAME_LEN_US);
    localparam int CMP_W    = (US_W > WIDTH_W) ? US_W : WIDTH_W;

    logic [PRE_W-1:0]                  pre_cnt;
    logic [US_W-1:0]                   us_cnt;
    logic                              us_tick;
    logic                              frame_start;
    servo_state_t                      state, state_next;
    axis_ctrl_t                        ctrl;
    logic [NUM_AXES-1:0][SAMPLE_W-1:0] samples;
    logic [NUM_AXES-1:0][WIDTH_W-1:0]  width_next;
    logic [NUM_AXES-1:0][WIDTH_W-1:0]  width_act;
    logic [NUM_AXES-1:0]               pwm_q;

    assign us_tick     = (pre_cnt == PRE_W'(US_DIV - 1));
    assign frame_start = us_tick && (us_cnt == US_W'(FRAME_LEN_US - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else begin
            pre_cnt <= us_tick ? '0 : pre_cnt + 1'b1;
            if (us_tick)
                us_cnt <= (us_cnt == US_W'(FRAME_LEN_US - 1)) ? '0 : us_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (frame_start && !hold) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_ACCUM;
            ST_ACCUM:   state_next = ST_SCALE;
            ST_SCALE:   state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl         = '0;
        ctrl.capture = (state == ST_CAPTURE);
        ctrl.accum   = (state == ST_ACCUM);
        ctrl.scale   = (state == ST_SCALE);
        ctrl.done    = (state == ST_DONE);
        sample_valid = (state == ST_DONE);
    end

    assign samples = {y_in, x_in};

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        servo_axis_map u_map (
            .clk        (clk),
            .rst        (rst),
            .ctrl       (ctrl),
            .sample     (samples[a]),
            .width_next (width_next[a])
        );
    end

    // Active widths only move on the frame boundary so a pulse is never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_AXES; a++)
                width_act[a] <= WIDTH_W'(CENTER_US);
            pwm_q <= '0;
        end else begin
            if (frame_start)
                width_act <= width_next;
            for (int a = 0; a < NUM_AXES; a++)
                pwm_q[a] <= (CMP_W'(us_cnt) < CMP_W'(width_act[a]));
        end
    end

    assign pwm_x   = pwm_q[0];
    assign pwm_y   = pwm_q[1];
    assign width_x = width_act[0];
    assign width_y = width_act[1];

endmodule
